// File: rtl/opti_sos_out_buf_if.sv
// Sample/handshake bundle between the last SOS stage, the output buffer and its consumer.
interface opti_sos_out_buf_if #(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic               data_valid_in;
  logic signed [15:0] data_in;
  logic signed [15:0] gain;
  logic               clr_flags;
  logic               out_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [LVL_W-1:0]   fifo_level;
  logic               overflow;
  logic               sat_flag;

  modport master (
    output data_valid_in, data_in, gain, clr_flags, out_ready,
    input  out_valid, out_data, fifo_level, overflow, sat_flag
  );

  modport slave (
    input  data_valid_in, data_in, gain, clr_flags, out_ready,
    output out_valid, out_data, fifo_level, overflow, sat_flag
  );
endinterface

// File: rtl/opti_sos_out_buf.sv
// SOS output buffer: Q2.14 x Q2.14 gain scaling to saturated Q1.15, then a FWFT FIFO.
// Optional build macro OPTI_SOS_ROUND_EN selects round-half-up instead of truncation.
module opti_sos_out_buf #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  opti_sos_out_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic signed [31:0] scale_shift(input logic signed [31:0] prod);
    logic signed [31:0] biased;
`ifdef OPTI_SOS_ROUND_EN
    biased = prod + 32'sd4096;
`else
    biased = prod;
`endif
    return biased >>> 13;
  endfunction

  function automatic logic is_sat(input logic signed [31:0] v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7fff;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  logic signed [31:0] prod_c;
  logic signed [31:0] shifted_c;
  logic               sat_evt_c;
  logic               full_c;
  logic               rd_c;
  logic               wr_c;
  logic               out_valid_c;

  logic               s1_valid_q, s1_valid_d;
  logic signed [15:0] s1_data_q, s1_data_d;
  logic signed [15:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               sat_q, sat_d;

  always_comb begin
    prod_c     = 32'(bus.data_in) * 32'(bus.gain);
    shifted_c  = scale_shift(prod_c);
    sat_evt_c  = bus.data_valid_in && is_sat(shifted_c);
    s1_valid_d = bus.data_valid_in;
    s1_data_d  = bus.data_valid_in ? sat16(shifted_c) : s1_data_q;

    // A full FIFO still takes the s1 sample when the consumer frees a slot this cycle.
    full_c   = (level_q == LW'(DEPTH));
    rd_c     = (level_q != '0) && bus.out_ready;
    wr_c     = s1_valid_q && (!full_c || rd_c);
    wr_ptr_d = wr_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_c ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (wr_c && !rd_c)      level_d = level_q + LW'(1);
    else if (rd_c && !wr_c) level_d = level_q - LW'(1);

    // Sticky flags: a set event beats a simultaneous clear.
    overflow_d = (s1_valid_q && !wr_c) ? 1'b1 : (bus.clr_flags ? 1'b0 : overflow_q);
    sat_d      = sat_evt_c ? 1'b1 : (bus.clr_flags ? 1'b0 : sat_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      sat_q      <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    if (wr_c) mem_q[wr_ptr_q] <= s1_data_q;
  end

  assign out_valid_c    = (level_q != '0);
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = out_valid_c ? mem_q[rd_ptr_q] : 16'sh0000;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_opti_sos_out_buf.sv
// Scoreboard bench for opti_sos_out_buf: queue-based reference model plus per-cycle monitor.
module tb_opti_sos_out_buf;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opti_sos_out_buf_if #(.DEPTH(DEPTH)) bus ();
  opti_sos_out_buf #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference conversion: exact product, optional +2^12, floor divide by 2^13, clamp.
  function automatic void conv(input logic signed [15:0] d, input logic signed [15:0] g,
                               output logic [15:0] res, output bit sat);
    longint p;
    longint v;
    p = longint'(d) * longint'(g);
`ifdef OPTI_SOS_ROUND_EN
    p = p + 4096;
`endif
    v = p >>> 13;
    sat = (v > 32767) || (v < -32768);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    res = v[15:0];
  endfunction

  logic [15:0] exp_q[$];
  bit          m_s1_v = 1'b0;
  logic [15:0] m_s1_d = 16'h0;
  bit          m_ovf  = 1'b0;
  bit          m_sat  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_s1_v = 1'b0;
      m_ovf  = 1'b0;
      m_sat  = 1'b0;
    end else begin
      bit          rd;
      bit          drop;
      int          sz;
      logic [15:0] nd;
      bit          ns;
      sz   = exp_q.size();
      rd   = (sz != 0) && bus.out_ready;
      drop = 1'b0;
      if (rd) void'(exp_q.pop_front());
      if (m_s1_v) begin
        if (sz < DEPTH || rd) exp_q.push_back(m_s1_d);
        else drop = 1'b1;
      end
      conv(bus.data_in, bus.gain, nd, ns);
      m_sat  = (bus.data_valid_in && ns) ? 1'b1 : (bus.clr_flags ? 1'b0 : m_sat);
      m_ovf  = drop ? 1'b1 : (bus.clr_flags ? 1'b0 : m_ovf);
      m_s1_v = bus.data_valid_in;
      m_s1_d = nd;
    end
  end

  always @(negedge clk) begin
    chk("mon_out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("mon_fifo_level", 32'(bus.fifo_level), 32'(exp_q.size()));
    chk("mon_overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("mon_sat_flag", 32'(bus.sat_flag), 32'(m_sat));
    if (exp_q.size() != 0) chk("mon_out_data", {16'h0, bus.out_data}, {16'h0, exp_q[0]});
  end

  task automatic drive(input bit v, input logic [15:0] d, input logic [15:0] g,
                       input bit rdy, input bit clr);
    bus.data_valid_in = v;
    bus.data_in       = d;
    bus.gain          = g;
    bus.out_ready     = rdy;
    bus.clr_flags     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    repeat (n) drive(1'b0, 16'h0, 16'h0, rdy, 1'b0);
  endtask

  logic [15:0] exp_r033;

  initial begin
    rst_n             = 1'b1;
    bus.data_valid_in = 1'b0;
    bus.data_in       = '0;
    bus.gain          = '0;
    bus.out_ready     = 1'b0;
    bus.clr_flags     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_sat_flag", 32'(bus.sat_flag), 32'd0);
    chk("rst_out_data", {16'h0, bus.out_data}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal scaling and N+2 latency pulse
    drive(1'b1, 16'h2000, 16'h4000, 1'b1, 1'b0);
    chk("lat_n1_valid", 32'(bus.out_valid), 32'd0);
    idle(1'b1, 1);
    chk("lat_n2_valid", 32'(bus.out_valid), 32'd1);
    chk("nominal_data", {16'h0, bus.out_data}, 32'h4000);
    chk("nominal_sat", 32'(bus.sat_flag), 32'd0);
    idle(1'b1, 1);
    chk("pulse_end_valid", 32'(bus.out_valid), 32'd0);

    // Negative full scale without and with saturation, then clear
    drive(1'b1, 16'hC000, 16'h4000, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("negfs_data", {16'h0, bus.out_data}, 32'h8000);
    chk("negfs_sat", 32'(bus.sat_flag), 32'd0);
    idle(1'b1, 2);
    drive(1'b1, 16'hC000, 16'h6000, 1'b1, 1'b0);
    chk("sat_set_n1", 32'(bus.sat_flag), 32'd1);
    idle(1'b1, 1);
    chk("sat_data", {16'h0, bus.out_data}, 32'h8000);
    idle(1'b1, 2);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("sat_cleared", 32'(bus.sat_flag), 32'd0);

    // Smallest product: rounding vs truncation
`ifdef OPTI_SOS_ROUND_EN
    exp_r033 = 16'h0001;
`else
    exp_r033 = 16'h0000;
`endif
    drive(1'b1, 16'h0001, 16'h1000, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("round_lsb_valid", 32'(bus.out_valid), 32'd1);
    chk("round_lsb_data", {16'h0, bus.out_data}, {16'h0, exp_r033});
    idle(1'b1, 2);

    // Overflow: DEPTH+2 strobes with consumer stalled
    for (int k = 1; k <= DEPTH + 2; k++) drive(1'b1, 16'(k), 16'h2000, 1'b0, 1'b0);
    idle(1'b0, 2);
    chk("ovf_level", 32'(bus.fifo_level), 32'(DEPTH));
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("ovf_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("ovf_drain_data", {16'h0, bus.out_data}, 32'(i));
      idle(1'b1, 1);
    end
    chk("ovf_drained_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Full FIFO with simultaneous read and write
    for (int k = 1; k <= DEPTH; k++) drive(1'b1, 16'(10 + k), 16'h2000, 1'b0, 1'b0);
    drive(1'b1, 16'd99, 16'h2000, 1'b0, 1'b0);
    chk("full_level", 32'(bus.fifo_level), 32'(DEPTH));
    idle(1'b1, 1);
    chk("rw_full_level", 32'(bus.fifo_level), 32'(DEPTH));
    chk("rw_full_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("rw_drain_data", {16'h0, bus.out_data}, (i < DEPTH - 1) ? 32'(12 + i) : 32'd99);
      idle(1'b1, 1);
    end
    chk("rw_drained_valid", 32'(bus.out_valid), 32'd0);

    // Randomized traffic, stalled then mostly flowing consumer
    for (int n = 0; n < 400; n++) begin
      bit          v;
      bit          rdy;
      bit          clr;
      logic [15:0] g;
      v   = ($urandom_range(0, 2) != 0);
      rdy = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      g   = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h4000));
      drive(v, 16'($urandom), g, rdy, clr);
    end
    idle(1'b1, DEPTH + 4);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);

    // Asynchronous reset mid-stream with samples queued and one in flight
    drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    drive(1'b1, 16'd5, 16'h2000, 1'b0, 1'b0);
    drive(1'b1, 16'd6, 16'h2000, 1'b0, 1'b0);
    drive(1'b1, 16'd7, 16'h2000, 1'b0, 1'b0);
    bus.data_valid_in = 1'b0;
    chk("pre_rst_level", 32'(bus.fifo_level), 32'd3);
    chk("pre_rst_sat", 32'(bus.sat_flag), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_level", 32'(bus.fifo_level), 32'd0);
    chk("mid_rst_sat", 32'(bus.sat_flag), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("mid_rst_data", {16'h0, bus.out_data}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 16'd3, 16'h2000, 1'b1, 1'b0);
    chk("post_rst_n1_valid", 32'(bus.out_valid), 32'd0);
    idle(1'b1, 1);
    chk("post_rst_n2_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data", {16'h0, bus.out_data}, 32'd3);
    idle(1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
